if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS core; sits directly upstream of decode and feeds the IF/ID boundary.
- Owns the program counter, issues word reads to a synchronous instruction memory (1-cycle read latency), and buffers returned instructions in a small queue so decode stalls never drop a fetched word.
- Accepts branch/jump redirects from downstream and flushes all wrong-path work.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- QUEUE_DEPTH, 2, instruction queue entries (legal range 2..8).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_init  in  ADDR_W  PC loaded on reset; bits [1:0] ignored (forced 0).
- imem_req  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  read address; data returns on imem_rdata one cycle later.
- imem_rdata  in  32  instruction word for the request issued the previous cycle.
- id_ready  in  1  decode can accept this cycle.
- if_valid  out  1  queue head holds a valid instruction.
- if_instr  out  32  queue-head instruction.
- if_pc  out  ADDR_W  address of if_instr.
- if_pc_plus4  out  ADDR_W  if_pc + 4, modulo 2^ADDR_W.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_target  in  ADDR_W  new fetch address.
- pc_out  out  ADDR_W  next address to be requested (debug/program_counter).
- fetch_fault  out  1  misaligned redirect seen (see Optional Feature).

Behaviour:
- Reset (rst=1 at edge): pc <= {pc_init[ADDR_W-1:2],2'b00}; queue empty; in-flight flag 0; fetch_fault 0. While rst=1: imem_req=0, if_valid=0, if_instr/if_pc/if_pc_plus4=0.
- Dequeue: deq = if_valid & id_ready & ~redirect_valid.
- Issue rule (no redirect): imem_req=1 iff count + inflight - deq < QUEUE_DEPTH; imem_addr=pc; on issue pc <= pc+4, inflight <= 1, else inflight <= 0.
- Response: if inflight=1, imem_rdata and its PC are written into the queue tail at the next edge; the queue never overflows by construction.
- if_valid = (count != 0); outputs come from registered queue head, no combinational path from imem_rdata.
- Latency: first rst-low cycle R issues pc_init; if_valid high in R+2. With id_ready held 1: one instruction per cycle, consecutive PCs.
- Stall: id_ready=0 -> head held stable (if_instr/if_pc unchanged); fetch continues until queue full, then imem_req=0.
- Redirect in cycle C (priority: rst > redirect > stall): queue flushed; the response arriving in C (request from C-1) discarded; imem_req=1, imem_addr=target same cycle; pc <= target+4; inflight <= 1. Target instruction visible with if_valid in C+2. if_valid shown during C is not consumed.
- Back-to-back redirects: each one flushes; only the last target survives.
- PC wrap: 0xFFFFFFFC + 4 -> 0x00000000, no fault.
- Reset mid-operation: any in-flight response is ignored; state is as in reset.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: redirect_target[1:0] != 0 sets fetch_fault (sticky until rst); the redirect flushes as normal, but imem_req stays 0 and if_valid stays 0 until reset.
- Undefined: target bits [1:0] forced to 0 and used; fetch_fault tied 0.

Test Plan:
- pc_init=600, id_ready=1 -> if_valid at R+2; if_pc sequence 600, 604, 608, one per cycle; if_pc_plus4 = 604, 608, 612.
- id_ready=0 for 5 cycles after the first instruction -> if_pc held at 600; imem_req drops after queue full (2 entries); on release, 600, 604, 608 with no gap or loss.
- Redirect to 700 in cycle C during streaming -> no instruction from the old path appears after C; if_pc=700 in C+2, then 704.
- Redirect in the same cycle as id_ready=0 with a full queue -> redirect wins; queue flushed; if_pc=700 in C+2.
- pc_init=0xFFFFFFF8 -> if_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; fetch_fault stays 0.
- FETCH_ALIGN_CHECK_EN on, redirect to 702 -> fetch_fault=1 next cycle; imem_req=0 and if_valid=0 thereafter; rst clears fetch_fault.

Source files
------------

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues 1-cycle imem reads, and buffers responses in a QUEUE_DEPTH-entry queue (head valid 2 cycles after reset/redirect).
// Decode stalls hold the head while fetch runs until the queue is full; `define FETCH_ALIGN_CHECK_EN makes a misaligned redirect raise a sticky fetch_fault.
module if_fetch_stage #(
  parameter int ADDR_W      = 32,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_init,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_fault
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } entry_t;

  entry_t             q [QUEUE_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;
  logic               fault_q;
  logic               redirect_ok;
  logic               deq;
  logic               issue;
  logic [ADDR_W-1:0]  target_al;
  logic [CNT_W:0]     occ;
  logic               unused_bits;

  // Low address bits are forced to zero, so they are intentionally unread.
  assign unused_bits = ^{pc_init[1:0], redirect_target[1:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(QUEUE_DEPTH - 1))
      return '0;
    else
      return p + PTR_W'(1);
  endfunction

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned  = (redirect_target[1:0] != 2'b00);
  assign redirect_ok = ~misaligned & ~fault_q;

  always_ff @(posedge clk) begin
    if (rst)
      fault_q <= 1'b0;
    else if (redirect_valid && misaligned)
      fault_q <= 1'b1;
  end
`else
  assign redirect_ok = 1'b1;
  assign fault_q     = 1'b0;
`endif

  // occ is the queue occupancy once the current response lands; issuing only
  // while occ < depth guarantees the next-cycle response always has a slot.
  always_comb begin
    target_al = {redirect_target[ADDR_W-1:2], 2'b00};
    deq       = if_valid & id_ready & ~redirect_valid;
    occ       = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(deq);
    issue     = 1'b0;
    imem_addr = pc;
    if (rst) begin
      issue = 1'b0;
    end else if (redirect_valid) begin
      issue     = redirect_ok;
      imem_addr = target_al;
    end else begin
      issue = ~fault_q & (occ < (CNT_W+1)'(QUEUE_DEPTH));
    end
    imem_req = issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= {pc_init[ADDR_W-1:2], 2'b00};
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      // Flush queue and drop the response arriving this cycle.
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight    <= issue;
      inflight_pc <= target_al;
      pc          <= target_al + ADDR_W'(4);
    end else begin
      if (inflight) begin
        q[tail] <= '{pc: inflight_pc, instr: imem_rdata};
        tail    <= ptr_inc(tail);
      end
      if (deq)
        head <= ptr_inc(head);
      count    <= count + CNT_W'(inflight) - CNT_W'(deq);
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_W'(4);
        inflight_pc <= pc;
      end
    end
  end

  assign if_valid    = ~rst & (count != '0);
  assign if_instr    = if_valid ? q[head].instr : '0;
  assign if_pc       = if_valid ? q[head].pc : '0;
  assign if_pc_plus4 = if_valid ? (q[head].pc + ADDR_W'(4)) : '0;
  assign pc_out      = pc;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: stream, stall, redirects, PC wrap and the optional alignment check.
`timescale 1ns/1ps
module tb_if_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_init;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_out;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  if_fetch_stage #(.ADDR_W(32), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_init(pc_init),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc_out(pc_out), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word content is address ^ KEY; junk when not read.
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_init = 32'd600; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0;

    // Reset state
    next_cyc(); next_cyc(); #2;
    check("rst_req", imem_req, 0);
    check("rst_valid", if_valid, 0);
    check("rst_pc", if_pc, 0);
    check("rst_plus4", if_pc_plus4, 0);
    check("rst_instr", if_instr, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_pc_out", pc_out, 32'd600);

    // Streaming from 600
    next_cyc(); rst = 1'b0; #2;
    check("R_req", imem_req, 1);
    check("R_addr", imem_addr, 32'd600);
    next_cyc(); #2;
    check("R1_valid", if_valid, 0);
    check("R1_addr", imem_addr, 32'd604);
    next_cyc(); #2;
    check("R2_valid", if_valid, 1);
    check("R2_pc", if_pc, 32'd600);
    check("R2_plus4", if_pc_plus4, 32'd604);
    check("R2_instr", if_instr, 32'd600 ^ KEY);
    next_cyc(); #2;
    check("R3_pc", if_pc, 32'd604);
    check("R3_plus4", if_pc_plus4, 32'd608);
    next_cyc(); #2;
    check("R4_pc", if_pc, 32'd608);
    check("R4_plus4", if_pc_plus4, 32'd612);

    // Reset mid-stream, then stall after first instruction
    next_cyc(); rst = 1'b1; #2;
    check("mrst_valid", if_valid, 0);
    check("mrst_req", imem_req, 0);
    next_cyc(); rst = 1'b0; #2;
    check("mR_addr", imem_addr, 32'd600);
    next_cyc(); #2;
    check("mR1_stale", if_valid, 0);
    next_cyc(); id_ready = 1'b0; #2;
    check("stall0_pc", if_pc, 32'd600);
    check("stall0_req", imem_req, 0);
    for (int i = 0; i < 4; i++) begin
      next_cyc(); #2;
      check("stall_pc", if_pc, 32'd600);
      check("stall_valid", if_valid, 1);
      check("stall_req", imem_req, 0);
      check("stall_pc_out", pc_out, 32'd608);
    end
    next_cyc(); id_ready = 1'b1; #2;
    check("rel_pc", if_pc, 32'd600);
    check("rel_req", imem_req, 1);
    check("rel_addr", imem_addr, 32'd608);
    next_cyc(); #2;
    check("rel1_pc", if_pc, 32'd604);
    next_cyc(); #2;
    check("rel2_pc", if_pc, 32'd608);

    // Redirect to 700 while streaming
    next_cyc(); redirect_valid = 1'b1; redirect_target = 32'd700; #2;
    check("C_req", imem_req, 1);
    check("C_addr", imem_addr, 32'd700);
    check("C_head", if_pc, 32'd612);
    next_cyc(); redirect_valid = 1'b0; #2;
    check("C1_flushed", if_valid, 0);
    check("C1_addr", imem_addr, 32'd704);
    next_cyc(); #2;
    check("C2_pc", if_pc, 32'd700);
    check("C2_instr", if_instr, 32'd700 ^ KEY);
    next_cyc(); #2;
    check("C3_pc", if_pc, 32'd704);

    // Redirect beats a stall with a full queue
    next_cyc(); id_ready = 1'b0; #2;
    check("F0_pc", if_pc, 32'd708);
    check("F0_req", imem_req, 0);
    next_cyc(); #2;
    check("F1_pc", if_pc, 32'd708);
    check("F1_req", imem_req, 0);
    next_cyc(); redirect_valid = 1'b1; redirect_target = 32'd800; #2;
    check("F2_req", imem_req, 1);
    check("F2_addr", imem_addr, 32'd800);
    next_cyc(); redirect_valid = 1'b0; id_ready = 1'b1; #2;
    check("F3_flushed", if_valid, 0);
    next_cyc(); #2;
    check("F4_pc", if_pc, 32'd800);

    // Back-to-back redirects: only the last survives
    next_cyc(); redirect_valid = 1'b1; redirect_target = 32'h1000; #2;
    check("B0_addr", imem_addr, 32'h1000);
    next_cyc(); redirect_target = 32'h2000; #2;
    check("B1_addr", imem_addr, 32'h2000);
    next_cyc(); redirect_valid = 1'b0; #2;
    check("B2_flushed", if_valid, 0);
    check("B2_addr", imem_addr, 32'h2004);
    next_cyc(); #2;
    check("B3_pc", if_pc, 32'h2000);
    next_cyc(); #2;
    check("B4_pc", if_pc, 32'h2004);

    // Misaligned redirect
`ifdef FETCH_ALIGN_CHECK_EN
    next_cyc(); redirect_valid = 1'b1; redirect_target = 32'd702; #2;
    check("A0_req", imem_req, 0);
    next_cyc(); redirect_valid = 1'b0; #2;
    check("A1_fault", fetch_fault, 1);
    for (int i = 0; i < 3; i++) begin
      next_cyc(); #2;
      check("A_req", imem_req, 0);
      check("A_valid", if_valid, 0);
      check("A_fault", fetch_fault, 1);
    end
    next_cyc(); rst = 1'b1; #2;
    next_cyc(); #2;
    check("A_rst_fault", fetch_fault, 0);
`else
    next_cyc(); redirect_valid = 1'b1; redirect_target = 32'd702; #2;
    check("A0_req", imem_req, 1);
    check("A0_addr", imem_addr, 32'd700);
    next_cyc(); redirect_valid = 1'b0; #2;
    check("A1_fault", fetch_fault, 0);
    check("A1_valid", if_valid, 0);
    next_cyc(); #2;
    check("A2_pc", if_pc, 32'd700);
`endif

    // PC wrap with unaligned pc_init low bits
    next_cyc(); rst = 1'b1; pc_init = 32'hFFFF_FFFB; #2;
    next_cyc(); #2;
    check("W_pc_out", pc_out, 32'hFFFF_FFF8);
    next_cyc(); rst = 1'b0; #2;
    check("W_addr", imem_addr, 32'hFFFF_FFF8);
    next_cyc(); #2;
    next_cyc(); #2;
    check("W2_pc", if_pc, 32'hFFFF_FFF8);
    check("W2_plus4", if_pc_plus4, 32'hFFFF_FFFC);
    next_cyc(); #2;
    check("W3_pc", if_pc, 32'hFFFF_FFFC);
    check("W3_plus4", if_pc_plus4, 32'h0000_0000);
    next_cyc(); #2;
    check("W4_pc", if_pc, 32'h0000_0000);
    check("W4_plus4", if_pc_plus4, 32'h0000_0004);
    check("W4_instr", if_instr, KEY);
    check("W4_fault", fetch_fault, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
